// File: rtl/change_dispenser.sv
// Purpose : pays out change as a sequence of 10-unit and 5-unit coin ejections, one coin at a time.
// Latency : first eject request 1 cycle after start; each ack is followed by GAP_CYCLES idle cycles; done 1 cycle after FIN.
// Backpr. : each eject request is held until eject_ack; start is ignored while a job runs; an ack timeout latches fault until reset.
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-low reset
//   start       one-cycle request to dispense `amount` (honoured only in IDLE)
//   amount      change to return; valid values are multiples of 5 in 0..MAX_AMOUNT
//   eject_ack   ejector acknowledge for the coin currently requested (honoured only in REQ)
//   eject10     registered request for one 10-unit coin
//   eject5      registered request for one 5-unit coin
//   busy        job in progress
//   done        one-cycle pulse on normal job completion
//   bad_req     one-cycle pulse when a start is rejected
//   fault       sticky ejector-timeout flag, cleared only by reset
//   tens_left   10-unit coins still owed in the current job
//   fives_left  5-unit coins still owed in the current job
module change_dispenser #(
   parameter int GAP_CYCLES  = 18000,
   parameter int ACK_TIMEOUT = 65535,
   parameter int MAX_AMOUNT  = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [5:0] amount,
   input  logic       eject_ack,
   output logic       eject10,
   output logic       eject5,
   output logic       busy,
   output logic       done,
   output logic       bad_req,
   output logic       fault,
   output logic [2:0] tens_left,
   output logic       fives_left
);

   // One counter serves both the GAP length and the ack timeout. It only
   // ever counts up to (limit - 1) and is cleared on entry to REQ and GAP,
   // so $clog2 of the larger limit is enough bits and it can never wrap.
   localparam int CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      GAP   = 3'd2,
      FIN   = 3'd3,
      FAULT = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // Decode of the requested amount, used only when a start arrives in IDLE.
   logic       amt_mult5;
   logic       amt_in_range;
   logic       amt_valid;
   logic       amt_zero;
   logic [2:0] load_tens;
   logic       load_fives;

   assign amt_mult5    = ((amount % 6'd5) == 6'd0);
   assign amt_in_range = (32'(amount) <= 32'(MAX_AMOUNT));
   assign amt_valid    = amt_mult5 && amt_in_range;
   assign amt_zero     = (amount == 6'd0);
   assign load_tens    = 3'(amount / 6'd10);
   // For a multiple of 5 the remainder mod 10 is either 0 or 5.
   assign load_fives   = ((amount % 6'd10) >= 6'd5);

   // Coins still owed after the most recent ack; decides REQ vs FIN at GAP end.
   logic coins_remain;
   assign coins_remain = (tens_left != 3'd0) || fives_left;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         eject10    <= 1'b0;
         eject5     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bad_req    <= 1'b0;
         fault      <= 1'b0;
         tens_left  <= 3'd0;
         fives_left <= 1'b0;
      end else begin
         // Pulse outputs default low; the states below raise them for one cycle.
         done    <= 1'b0;
         bad_req <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  if (amt_valid) begin
                     tens_left  <= load_tens;
                     fives_left <= load_fives;
                     busy       <= 1'b1;
                     cnt        <= '0;
                     if (amt_zero) begin
                        // Nothing to pay out: complete without touching the ejector.
                        state <= FIN;
                     end else begin
                        state   <= REQ;
                        // Tens are always paid before the single possible five.
                        eject10 <= (load_tens != 3'd0);
                        eject5  <= (load_tens == 3'd0);
                     end
                  end else begin
                     bad_req <= 1'b1;
                  end
               end
            end

            REQ: begin
               if (eject_ack) begin
                  eject10 <= 1'b0;
                  eject5  <= 1'b0;
                  // The registered request identifies which coin was just paid.
                  if (eject10) begin
                     tens_left <= tens_left - 3'd1;
                  end else begin
                     fives_left <= 1'b0;
                  end
                  cnt   <= '0;
                  state <= GAP;
               end else if (cnt == TMO_LAST) begin
                  // Ejector never answered: abandon the job and latch the fault.
                  eject10 <= 1'b0;
                  eject5  <= 1'b0;
                  busy    <= 1'b0;
                  fault   <= 1'b1;
                  state   <= FAULT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt <= '0;
                  if (coins_remain) begin
                     state   <= REQ;
                     eject10 <= (tens_left != 3'd0);
                     eject5  <= (tens_left == 3'd0);
                  end else begin
                     state <= FIN;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end

            FAULT: begin
               // Terminal until reset; start and eject_ack are not looked at.
               state <= FAULT;
            end

            default: begin
               state   <= IDLE;
               eject10 <= 1'b0;
               eject5  <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Purpose : directed self-checking bench for change_dispenser with GAP_CYCLES=4, ACK_TIMEOUT=8.
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpr. : the bench plays the coin ejector, acking each request after a chosen delay.
module tb_change_dispenser;

   localparam int GAP = 4;
   localparam int TMO = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [5:0] amount = 6'd0;
   logic       eject_ack = 1'b0;
   logic       eject10;
   logic       eject5;
   logic       busy;
   logic       done;
   logic       bad_req;
   logic       fault;
   logic [2:0] tens_left;
   logic       fives_left;

   int n_total = 0;
   int n_pass  = 0;

   // Event counters kept by the monitor only; the stimulus reads snapshots.
   int e10_rise = 0;
   int e5_rise  = 0;
   int done_cnt = 0;
   int bad_cnt  = 0;
   int both_hi  = 0;
   logic prev10 = 1'b0;
   logic prev5  = 1'b0;

   change_dispenser #(
      .GAP_CYCLES (GAP),
      .ACK_TIMEOUT(TMO),
      .MAX_AMOUNT (50)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .amount    (amount),
      .eject_ack (eject_ack),
      .eject10   (eject10),
      .eject5    (eject5),
      .busy      (busy),
      .done      (done),
      .bad_req   (bad_req),
      .fault     (fault),
      .tens_left (tens_left),
      .fives_left(fives_left)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (eject10 && !prev10) e10_rise = e10_rise + 1;
      if (eject5 && !prev5)   e5_rise  = e5_rise + 1;
      if (done)               done_cnt = done_cnt + 1;
      if (bad_req)            bad_cnt  = bad_cnt + 1;
      if (eject10 && eject5)  both_hi  = both_hi + 1;
      prev10 = eject10;
      prev5  = eject5;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached (observed running, required finished)");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic pulse_start(input logic [5:0] amt);
      start  = 1'b1;
      amount = amt;
      tick();
      start  = 1'b0;
   endtask

   // Waits (bounded) until a request is showing.
   task automatic wait_req();
      int n;
      n = 0;
      while (!(eject10 || eject5) && n < 20) begin
         tick();
         n++;
      end
      chk("req_seen", eject10 || eject5, 1);
   endtask

   // Serves one coin: checks request kind, acks after dly cycles, checks the
   // count update and the exact GAP length. Optionally injects a stray start
   // and ack during the gap.
   task automatic do_coin(input int dly, input logic exp10, input logic [2:0] tens_after,
                          input logic fives_after, input logic more, input logic stray);
      wait_req();
      chk("req_is10", eject10, exp10);
      chk("req_is5", eject5, !exp10);
      repeat (dly) tick();
      chk("req_hold", eject10 || eject5, 1);
      eject_ack = 1'b1;
      tick();
      eject_ack = 1'b0;
      chk("ack_drop", eject10 || eject5, 0);
      chk("tens_after", tens_left, tens_after);
      chk("fives_after", fives_left, fives_after);
      for (int i = 0; i < GAP - 1; i++) begin
         if (stray && i == 0) begin
            start     = 1'b1;
            amount    = 6'd5;
            eject_ack = 1'b1;
         end
         tick();
         start     = 1'b0;
         eject_ack = 1'b0;
      end
      chk("gap_quiet", eject10 || eject5, 0);
      chk("gap_tens", tens_left, tens_after);
      chk("gap_fives", fives_left, fives_after);
      tick();
      chk("gap_end", eject10 || eject5, more);
   endtask

   // Called while in FIN.
   task automatic finish_job();
      chk("fin_done_lo", done, 0);
      chk("fin_busy", busy, 1);
      tick();
      chk("done_pulse", done, 1);
      chk("busy_clear", busy, 0);
      tick();
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      int s10, s5, sd, sb, n;

      // ---- reset state ----
      rst = 1'b0;
      tick();
      tick();
      chk("rst_eject10", eject10, 0);
      chk("rst_eject5", eject5, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_bad", bad_req, 0);
      chk("rst_fault", fault, 0);
      chk("rst_tens", tens_left, 0);
      chk("rst_fives", fives_left, 0);
      rst = 1'b1;
      tick();

      // ---- amount 25: 10, 10, 5 ----
      s10 = e10_rise; s5 = e5_rise; sd = done_cnt;
      pulse_start(6'd25);
      chk("a25_busy", busy, 1);
      chk("a25_tens", tens_left, 2);
      chk("a25_fives", fives_left, 1);
      do_coin(2, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0);
      do_coin(2, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
      do_coin(2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      finish_job();
      chk("a25_n10", e10_rise - s10, 2);
      chk("a25_n5", e5_rise - s5, 1);
      chk("a25_ndone", done_cnt - sd, 1);

      // ---- invalid amounts 7 and 55 ----
      s10 = e10_rise; s5 = e5_rise; sb = bad_cnt;
      pulse_start(6'd7);
      chk("bad7_pulse", bad_req, 1);
      chk("bad7_busy", busy, 0);
      tick();
      chk("bad7_one_cycle", bad_req, 0);
      pulse_start(6'd55);
      chk("bad55_pulse", bad_req, 1);
      chk("bad55_busy", busy, 0);
      tick();
      tick();
      chk("bad_count", bad_cnt - sb, 2);
      chk("bad_no_eject", (e10_rise - s10) + (e5_rise - s5), 0);
      chk("bad_idle_busy", busy, 0);

      // ---- amount 0 ----
      s10 = e10_rise; s5 = e5_rise; sd = done_cnt;
      pulse_start(6'd0);
      chk("zero_no_eject", eject10 || eject5, 0);
      finish_job();
      chk("zero_ndone", done_cnt - sd, 1);
      chk("zero_no_rise", (e10_rise - s10) + (e5_rise - s5), 0);

      // ---- amount 10, ack never comes -> fault ----
      pulse_start(6'd10);
      n = 0;
      while (eject10 && n < 20) begin
         n++;
         tick();
      end
      chk("tmo_high_cycles", n, TMO);
      chk("tmo_fault", fault, 1);
      chk("tmo_busy", busy, 0);
      chk("tmo_eject", eject10 || eject5, 0);
      s10 = e10_rise; s5 = e5_rise;
      pulse_start(6'd5);
      eject_ack = 1'b1;
      tick();
      eject_ack = 1'b0;
      tick();
      chk("fault_ignores_start", (e10_rise - s10) + (e5_rise - s5), 0);
      chk("fault_busy", busy, 0);
      chk("fault_sticky", fault, 1);
      rst = 1'b0;
      tick();
      chk("fault_cleared", fault, 0);
      rst = 1'b1;
      tick();

      // ---- amount 50 with stray start/ack in a gap ----
      s10 = e10_rise; s5 = e5_rise; sd = done_cnt;
      pulse_start(6'd50);
      chk("a50_tens", tens_left, 5);
      chk("a50_fives", fives_left, 0);
      do_coin(1, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1);
      do_coin(1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0);
      do_coin(1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1);
      do_coin(1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
      do_coin(1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      finish_job();
      chk("a50_n10", e10_rise - s10, 5);
      chk("a50_n5", e5_rise - s5, 0);
      chk("a50_ndone", done_cnt - sd, 1);

      // ---- reset during second request of amount 20 ----
      sd = done_cnt;
      pulse_start(6'd20);
      do_coin(1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
      wait_req();
      chk("a20_second_is10", eject10, 1);
      rst = 1'b0;
      tick();
      chk("mid_rst_eject10", eject10, 0);
      chk("mid_rst_eject5", eject5, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_bad", bad_req, 0);
      chk("mid_rst_fault", fault, 0);
      chk("mid_rst_tens", tens_left, 0);
      chk("mid_rst_fives", fives_left, 0);
      tick();
      chk("mid_rst_hold", eject10 || eject5 || busy || done, 0);
      rst = 1'b1;
      tick();
      chk("a20_no_done", done_cnt - sd, 0);
      s10 = e10_rise; s5 = e5_rise;
      pulse_start(6'd5);
      chk("a5_tens", tens_left, 0);
      chk("a5_fives", fives_left, 1);
      do_coin(1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      finish_job();
      chk("a5_n5", e5_rise - s5, 1);
      chk("a5_n10", e10_rise - s10, 0);
      chk("a5_ndone", done_cnt - sd, 1);

      chk("never_both", both_hi, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
